// File: rtl/mc_control_pkg.sv
// ============================================================================
//  Module   : mc_control_pkg
//  Purpose  : Shared types and constants for the multicycle RV32I control unit.
//             The MULDIV_WAIT state only exists when M_MODULE_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH       = 3'd0,
        ST_DECODE      = 3'd1,
        ST_EXECUTE     = 3'd2,
        ST_MEM         = 3'd3,
        ST_WRITEBACK   = 3'd4,
`ifdef M_MODULE_EN
        ST_MULDIV_WAIT = 3'd5,
`endif
        ST_ERROR       = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_OP_SEC, CLS_AUIPC,
        CLS_LUI, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_FENCE, CLS_MULDIV
    } opclass_t;

    localparam logic [2:0] ALU_OP_ZERO      = 3'b000;
    localparam logic [2:0] ALU_OP_ADD       = 3'b001;
    localparam logic [2:0] ALU_OP_DEFAULT   = 3'b010;
    localparam logic [2:0] ALU_OP_SECONDARY = 3'b011;
    localparam logic [2:0] ALU_OP_M         = 3'b101;

    localparam logic [2:0] WB_SEL_ALU = 3'b000;
    localparam logic [2:0] WB_SEL_MEM = 3'b001;
    localparam logic [2:0] WB_SEL_PC4 = 3'b010;
    localparam logic [2:0] WB_SEL_IMM = 3'b011;

    typedef struct packed {
        logic       fetch;
        logic       ir_we;
        logic       pc_we;
        logic       rf_we;
        logic       a_sel;
        logic       b_sel;
        logic [2:0] alu_op;
        logic       jal;
        logic       jalr;
        logic       branch;
        logic       rd;
        logic       wr;
        logic [2:0] wb_sel;
        logic       md_start;
    } ctrl_t;

    // Control word presented while sitting in state st with instruction class cls.
    function automatic ctrl_t ctrl_for(input state_t st, input opclass_t cls);
        ctrl_t c;
        ctrl_t alu;
        alu = '0;
        case (cls)
            CLS_LOAD, CLS_STORE, CLS_JALR: begin alu.b_sel = 1'b1; alu.alu_op = ALU_OP_ADD; end
            CLS_AUIPC, CLS_JAL: begin
                alu.a_sel  = 1'b1;
                alu.b_sel  = 1'b1;
                alu.alu_op = ALU_OP_ADD;
            end
            CLS_OP_IMM: begin alu.b_sel = 1'b1; alu.alu_op = ALU_OP_DEFAULT; end
            CLS_OP:     alu.alu_op = ALU_OP_DEFAULT;
            CLS_OP_SEC: alu.alu_op = ALU_OP_SECONDARY;
            CLS_BRANCH: alu.alu_op = ALU_OP_ADD;
            CLS_MULDIV: alu.alu_op = ALU_OP_M;
            default:    alu.alu_op = ALU_OP_ZERO;
        endcase

        c = '0;
        case (st)
            ST_FETCH:  c.fetch = 1'b1;
            ST_DECODE: c.ir_we = 1'b1;
            ST_EXECUTE: begin
                c          = alu;
                c.md_start = (cls == CLS_MULDIV);
            end
            ST_MEM: begin
                c    = alu;
                c.rd = (cls == CLS_LOAD);
                c.wr = (cls == CLS_STORE);
            end
`ifdef M_MODULE_EN
            ST_MULDIV_WAIT: c = alu;
`endif
            ST_WRITEBACK: begin
                c        = alu;
                c.pc_we  = 1'b1;
                c.jal    = (cls == CLS_JAL);
                c.jalr   = (cls == CLS_JALR);
                c.branch = (cls == CLS_BRANCH);
                c.rf_we  = !(cls == CLS_STORE || cls == CLS_BRANCH || cls == CLS_FENCE);
                case (cls)
                    CLS_LOAD:          c.wb_sel = WB_SEL_MEM;
                    CLS_JAL, CLS_JALR: c.wb_sel = WB_SEL_PC4;
                    CLS_LUI:           c.wb_sel = WB_SEL_IMM;
                    default:           c.wb_sel = WB_SEL_ALU;
                endcase
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_opcode_decoder.sv
// ============================================================================
//  Module   : mc_opcode_decoder
//  Purpose  : Combinational opcode classifier; with M_MODULE_EN, OP with
//             bit30 = 0 and bit25 = 1 is classified as a mul/div op.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_opcode_decoder
    import mc_control_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic       i_bit_30,
    input  logic       i_bit_25,
    output opclass_t   o_class,
    output logic       o_legal
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

`ifndef M_MODULE_EN
    logic w_unused_bit25;
    assign w_unused_bit25 = i_bit_25;
`endif

    always_comb begin
        o_class = CLS_FENCE;
        o_legal = 1'b1;
        case (i_opcode)
            OPC_LOAD:     o_class = CLS_LOAD;
            OPC_STORE:    o_class = CLS_STORE;
            OPC_OP_IMM:   o_class = CLS_OP_IMM;
            OPC_OP: begin
`ifdef M_MODULE_EN
                if (!i_bit_30 && i_bit_25)
                    o_class = CLS_MULDIV;
                else
`endif
                    o_class = i_bit_30 ? CLS_OP_SEC : CLS_OP;
            end
            OPC_AUIPC:    o_class = CLS_AUIPC;
            OPC_LUI:      o_class = CLS_LUI;
            OPC_BRANCH:   o_class = CLS_BRANCH;
            OPC_JAL:      o_class = CLS_JAL;
            OPC_JALR:     o_class = CLS_JALR;
            OPC_MISC_MEM: o_class = CLS_FENCE;
            default:      o_legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Multicycle RV32I control sequencer (FETCH/DECODE/EXECUTE/MEM/WB)
//             with memory wait-state timeout; M_MODULE_EN adds mul/div sequencing.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_fsm
    import mc_control_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 3,
    parameter int WB_SEL_WIDTH = 3,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              inst_opcode,
    input  logic                    inst_bit_30,
    input  logic                    inst_bit_25,
    input  logic                    mem_ready,
    input  logic                    muldiv_done,
    output logic                    inst_fetch_enable,
    output logic                    ir_write_enable,
    output logic                    pc_write_enable,
    output logic                    regfile_write_enable,
    output logic                    alu_operand_a_select,
    output logic                    alu_operand_b_select,
    output logic [ALU_OP_WIDTH-1:0] alu_op_type,
    output logic                    jal_enable,
    output logic                    jalr_enable,
    output logic                    branch_enable,
    output logic                    data_mem_read_enable,
    output logic                    data_mem_write_enable,
    output logic [WB_SEL_WIDTH-1:0] reg_writeback_select,
    output logic                    muldiv_start,
    output logic                    illegal_inst,
    output logic                    mem_timeout
);

    localparam int c_cnt_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_wait_limit = c_cnt_w'(MEM_TIMEOUT);

    state_t               r_state;
    opclass_t             r_class;
    ctrl_t                r_ctrl;
    logic [c_cnt_w-1:0]   r_wait_cnt;
    logic                 r_illegal;
    logic                 r_timeout;

    opclass_t             w_class;
    opclass_t             w_next_class;
    state_t               w_next_state;
    logic                 w_legal;
    logic                 w_mem_phase;
    logic                 w_limit;
    logic                 w_count_en;

    mc_opcode_decoder u_decoder (
        .i_opcode (inst_opcode),
        .i_bit_30 (inst_bit_30),
        .i_bit_25 (inst_bit_25),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    // A fetch only counts as outstanding once the request has actually been driven.
    assign w_mem_phase  = (r_state == ST_FETCH && r_ctrl.fetch) || (r_state == ST_MEM);
    assign w_limit      = (MEM_TIMEOUT != 0) && (r_wait_cnt == c_wait_limit);
    assign w_count_en   = w_mem_phase && !mem_ready && !w_limit && (MEM_TIMEOUT != 0);
    assign w_next_class = (r_state == ST_DECODE) ? w_class : r_class;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (r_ctrl.fetch) begin
                    if (mem_ready)    w_next_state = ST_DECODE;
                    else if (w_limit) w_next_state = ST_ERROR;
                end
            end
            ST_DECODE: w_next_state = w_legal ? ST_EXECUTE : ST_ERROR;
            ST_EXECUTE: begin
                if (r_class == CLS_LOAD || r_class == CLS_STORE)
                    w_next_state = ST_MEM;
`ifdef M_MODULE_EN
                else if (r_class == CLS_MULDIV)
                    w_next_state = ST_MULDIV_WAIT;
`endif
                else
                    w_next_state = ST_WRITEBACK;
            end
            ST_MEM: begin
                if (mem_ready)    w_next_state = ST_WRITEBACK;
                else if (w_limit) w_next_state = ST_ERROR;
            end
`ifdef M_MODULE_EN
            ST_MULDIV_WAIT: if (muldiv_done) w_next_state = ST_WRITEBACK;
`endif
            ST_WRITEBACK: w_next_state = ST_FETCH;
            default:      w_next_state = ST_ERROR;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_class    <= CLS_FENCE;
            r_ctrl     <= '0;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_class    <= w_next_class;
            r_ctrl     <= ctrl_for(w_next_state, w_next_class);
            r_wait_cnt <= w_count_en ? r_wait_cnt + 1'b1 : '0;
            if (r_state == ST_DECODE && !w_legal)
                r_illegal <= 1'b1;
            if (w_mem_phase && !mem_ready && w_limit)
                r_timeout <= 1'b1;
        end
    end

    assign inst_fetch_enable     = r_ctrl.fetch;
    assign ir_write_enable       = r_ctrl.ir_we;
    assign pc_write_enable       = r_ctrl.pc_we;
    assign regfile_write_enable  = r_ctrl.rf_we;
    assign alu_operand_a_select  = r_ctrl.a_sel;
    assign alu_operand_b_select  = r_ctrl.b_sel;
    assign alu_op_type           = ALU_OP_WIDTH'(r_ctrl.alu_op);
    assign jal_enable            = r_ctrl.jal;
    assign jalr_enable           = r_ctrl.jalr;
    assign branch_enable         = r_ctrl.branch;
    assign data_mem_read_enable  = r_ctrl.rd;
    assign data_mem_write_enable = r_ctrl.wr;
    assign reg_writeback_select  = WB_SEL_WIDTH'(r_ctrl.wb_sel);
    assign illegal_inst          = r_illegal;
    assign mem_timeout           = r_timeout;

`ifdef M_MODULE_EN
    assign muldiv_start = r_ctrl.md_start;
`else
    logic [1:0] w_unused_md;
    assign w_unused_md  = {r_ctrl.md_start, muldiv_done};
    assign muldiv_start = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// ============================================================================
//  Module   : tb_multicycle_control_fsm
//  Purpose  : Directed, scoreboard-checked bench for multicycle_control_fsm
//             (exercises the M_MODULE_EN path when that macro is defined).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] opc;
    logic       b30;
    logic       b25;
    logic       rdy;
    logic       md_done;

    logic       fe, irw, pcw, rfw, asel, bsel, jal, jalr, br, rd, wr, mds, ill, tmo;
    logic [2:0] aop, wbs;
    logic [19:0] got;

    typedef struct {
        string       name;
        logic [19:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks = 0;
    int errors = 0;

    multicycle_control_fsm #(
        .ALU_OP_WIDTH (3),
        .WB_SEL_WIDTH (3),
        .MEM_TIMEOUT  (4)
    ) dut (
        .clock                 (clk),
        .reset                 (rst),
        .inst_opcode           (opc),
        .inst_bit_30           (b30),
        .inst_bit_25           (b25),
        .mem_ready             (rdy),
        .muldiv_done           (md_done),
        .inst_fetch_enable     (fe),
        .ir_write_enable       (irw),
        .pc_write_enable       (pcw),
        .regfile_write_enable  (rfw),
        .alu_operand_a_select  (asel),
        .alu_operand_b_select  (bsel),
        .alu_op_type           (aop),
        .jal_enable            (jal),
        .jalr_enable           (jalr),
        .branch_enable         (br),
        .data_mem_read_enable  (rd),
        .data_mem_write_enable (wr),
        .reg_writeback_select  (wbs),
        .muldiv_start          (mds),
        .illegal_inst          (ill),
        .mem_timeout           (tmo)
    );

    assign got = {fe, irw, pcw, rfw, asel, bsel, aop, jal, jalr, br, rd, wr, wbs, mds, ill, tmo};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] ev(input logic f, i, p, r, a, b, input logic [2:0] op,
                                       input logic jl, jr, bc, mr, mw, input logic [2:0] wb,
                                       input logic md, il, to);
        return {f, i, p, r, a, b, op, jl, jr, bc, mr, mw, wb, md, il, to};
    endfunction

    // Monitor: one control word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            checks++;
            if (got !== it.exp) begin
                errors++;
                $display("FAIL %s: got %05h expected %05h", it.name, got, it.exp);
            end
        end
    end

    task automatic cyc(input string nm, input logic [19:0] e);
        sb_q.push_back('{name: nm, exp: e});
        @(posedge clk);
        #1;
    endtask

    logic [19:0] Z, EF, ED;

    initial begin
        Z  = '0;
        EF = ev(1,0,0,0,0,0,3'b000,0,0,0,0,0,3'b000,0,0,0);
        ED = ev(0,1,0,0,0,0,3'b000,0,0,0,0,0,3'b000,0,0,0);
        rst = 1'b1; opc = 7'b0010011; b30 = 1'b0; b25 = 1'b0; rdy = 1'b0; md_done = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_hold", Z);
        cyc("reset_hold2", Z);

        // ADDI, zero wait states
        rst = 1'b0; rdy = 1'b1;
        cyc("post_reset_idle", Z);
        cyc("addi_fetch", EF);
        cyc("addi_decode", ED);
        cyc("addi_execute", ev(0,0,0,0,0,1,3'b010,0,0,0,0,0,3'b000,0,0,0));
        cyc("addi_wb",      ev(0,0,1,1,0,1,3'b010,0,0,0,0,0,3'b000,0,0,0));

        // LW with three wait states in MEM
        opc = 7'b0000011;
        cyc("lw_fetch", EF);
        cyc("lw_decode", ED);
        cyc("lw_execute", ev(0,0,0,0,0,1,3'b001,0,0,0,0,0,3'b000,0,0,0));
        rdy = 1'b0;
        for (int k = 0; k < 3; k++)
            cyc("lw_mem_wait", ev(0,0,0,0,0,1,3'b001,0,0,0,1,0,3'b000,0,0,0));
        rdy = 1'b1;
        cyc("lw_mem_done", ev(0,0,0,0,0,1,3'b001,0,0,0,1,0,3'b000,0,0,0));
        cyc("lw_wb",       ev(0,0,1,1,0,1,3'b001,0,0,0,0,0,3'b001,0,0,0));

        // SW: write pulse, no register write
        opc = 7'b0100011;
        cyc("sw_fetch", EF);
        cyc("sw_decode", ED);
        cyc("sw_execute", ev(0,0,0,0,0,1,3'b001,0,0,0,0,0,3'b000,0,0,0));
        cyc("sw_mem",     ev(0,0,0,0,0,1,3'b001,0,0,0,0,1,3'b000,0,0,0));
        cyc("sw_wb",      ev(0,0,1,0,0,1,3'b001,0,0,0,0,0,3'b000,0,0,0));

        // JAL
        opc = 7'b1101111;
        cyc("jal_fetch", EF);
        cyc("jal_decode", ED);
        cyc("jal_execute", ev(0,0,0,0,1,1,3'b001,0,0,0,0,0,3'b000,0,0,0));
        cyc("jal_wb",      ev(0,0,1,1,1,1,3'b001,1,0,0,0,0,3'b010,0,0,0));

        // SUB: OP with bit30 selects the secondary function
        opc = 7'b0110011; b30 = 1'b1;
        cyc("sub_fetch", EF);
        cyc("sub_decode", ED);
        cyc("sub_execute", ev(0,0,0,0,0,0,3'b011,0,0,0,0,0,3'b000,0,0,0));
        cyc("sub_wb",      ev(0,0,1,1,0,0,3'b011,0,0,0,0,0,3'b000,0,0,0));

        // OP with bit25 set: MUL when the M extension is built in, plain OP otherwise
        b30 = 1'b0; b25 = 1'b1;
        cyc("mul_fetch", EF);
        cyc("mul_decode", ED);
`ifdef M_MODULE_EN
        cyc("mul_execute", ev(0,0,0,0,0,0,3'b101,0,0,0,0,0,3'b000,1,0,0));
        for (int k = 0; k < 5; k++)
            cyc("mul_wait", ev(0,0,0,0,0,0,3'b101,0,0,0,0,0,3'b000,0,0,0));
        md_done = 1'b1;
        cyc("mul_wait_done", ev(0,0,0,0,0,0,3'b101,0,0,0,0,0,3'b000,0,0,0));
        md_done = 1'b0;
        cyc("mul_wb",        ev(0,0,1,1,0,0,3'b101,0,0,0,0,0,3'b000,0,0,0));
`else
        md_done = 1'b1;
        cyc("op25_execute", ev(0,0,0,0,0,0,3'b010,0,0,0,0,0,3'b000,0,0,0));
        cyc("op25_wb",      ev(0,0,1,1,0,0,3'b010,0,0,0,0,0,3'b000,0,0,0));
        md_done = 1'b0;
`endif
        b25 = 1'b0;

        // Illegal opcode -> absorbing ERROR with sticky flag
        opc = 7'b1111111;
        cyc("ill_fetch", EF);
        cyc("ill_decode", ED);
        cyc("ill_error", ev(0,0,0,0,0,0,3'b000,0,0,0,0,0,3'b000,0,1,0));
        cyc("ill_error_hold", ev(0,0,0,0,0,0,3'b000,0,0,0,0,0,3'b000,0,1,0));
        rst = 1'b1;
        cyc("ill_reset", Z);
        rst = 1'b0;
        cyc("ill_post_reset", Z);

        // LW interrupted by reset while waiting in MEM
        opc = 7'b0000011;
        cyc("lwr_fetch", EF);
        cyc("lwr_decode", ED);
        cyc("lwr_execute", ev(0,0,0,0,0,1,3'b001,0,0,0,0,0,3'b000,0,0,0));
        rdy = 1'b0;
        cyc("lwr_mem", ev(0,0,0,0,0,1,3'b001,0,0,0,1,0,3'b000,0,0,0));
        rst = 1'b1;
        cyc("lwr_reset_mid_mem", Z);
        rst = 1'b0;
        cyc("lwr_post_reset", Z);

        // Fetch never completes: timeout after MEM_TIMEOUT+1 request cycles
        for (int k = 0; k < 5; k++)
            cyc("to_fetch_wait", EF);
        cyc("to_error", ev(0,0,0,0,0,0,3'b000,0,0,0,0,0,3'b000,0,0,1));
        rdy = 1'b1;
        cyc("to_error_hold", ev(0,0,0,0,0,0,3'b000,0,0,0,0,0,3'b000,0,0,1));
        cyc("to_error_hold2", ev(0,0,0,0,0,0,3'b000,0,0,0,0,0,3'b000,0,0,1));

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, 0 required", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
